// File: rtl/cc_rresp_serializer_if.sv
// Request-FIFO head, memory R channel and INCT R channel of the read-response serializer.
// The slave modport is the serializer's view; the master modport is its environment's view.
interface cc_rresp_serializer_if #(
  parameter int unsigned BEAT_W  = 64,
  parameter int unsigned N_BEATS = 8
);
  localparam int unsigned LINE_W = BEAT_W * N_BEATS;

  logic              req_valid_i;
  logic              req_hit_i;
  logic [5:0]        req_offset_i;
  logic [LINE_W-1:0] req_line_i;
  logic              req_pop_o;

  logic [BEAT_W-1:0] mem_rdata_i;
  logic              mem_rlast_i;
  logic              mem_rvalid_i;
  logic              mem_rready_o;

  logic [BEAT_W-1:0] inct_rdata_o;
  logic              inct_rlast_o;
  logic              inct_rvalid_o;
  logic              inct_rready_i;

  logic              err_o;

  modport slave (
    input  req_valid_i, req_hit_i, req_offset_i, req_line_i,
    output req_pop_o,
    input  mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    output mem_rready_o,
    output inct_rdata_o, inct_rlast_o, inct_rvalid_o,
    input  inct_rready_i,
    output err_o
  );

  modport master (
    output req_valid_i, req_hit_i, req_offset_i, req_line_i,
    input  req_pop_o,
    output mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    input  mem_rready_o,
    input  inct_rdata_o, inct_rlast_o, inct_rvalid_o,
    output inct_rready_i,
    input  err_o
  );
endinterface

// File: rtl/cc_rresp_serializer.sv
// Serializes a cache line (hit) or passes a memory WRAP burst (miss) onto INCT, critical word first.
// Optional macro CC_RRESP_LAST_CHECK_EN: miss bursts end on mem_rlast_i and rlast misplacement sets err_o.
module cc_rresp_serializer #(
  parameter int unsigned BEAT_W  = 64,
  parameter int unsigned N_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cc_rresp_serializer_if.slave  bus
);

  localparam int unsigned LINE_W = BEAT_W * N_BEATS;
  localparam int unsigned IDX_W  = $clog2(N_BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIT  = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [LINE_W-1:0] line_q, line_d;
`ifdef CC_RRESP_LAST_CHECK_EN
  logic              err_q, err_d;
`endif

  logic              pop_c, mem_rready_c, rvalid_c, rlast_c;
  logic [BEAT_W-1:0] rdata_c;
  logic [IDX_W-1:0]  word_idx;
  logic              last_beat, mem_hs;

  // Index arithmetic wraps naturally in IDX_W bits (word N_BEATS-1 -> word 0).
  assign word_idx  = start_q + cnt_q;
  assign last_beat = (cnt_q == LAST_IDX);
  assign mem_hs    = bus.mem_rvalid_i & bus.inct_rready_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    line_d       = line_q;
`ifdef CC_RRESP_LAST_CHECK_EN
    err_d        = err_q;
`endif
    pop_c        = 1'b0;
    mem_rready_c = 1'b0;
    rvalid_c     = 1'b0;
    rlast_c      = 1'b0;
    rdata_c      = '0;

    case (state_q)
      ST_IDLE: begin
        pop_c = bus.req_valid_i;
        if (bus.req_valid_i) begin
          line_d  = bus.req_line_i;
          start_d = IDX_W'(bus.req_offset_i[5:3]);
          cnt_d   = '0;
          state_d = bus.req_hit_i ? ST_HIT : ST_MISS;
        end
      end
      ST_HIT: begin
        rvalid_c = 1'b1;
        rdata_c  = line_q[BEAT_W*word_idx +: BEAT_W];
        rlast_c  = last_beat;
        if (bus.inct_rready_i) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (last_beat) state_d = ST_IDLE;
        end
      end
      ST_MISS: begin
        rvalid_c     = bus.mem_rvalid_i;
        rdata_c      = bus.mem_rdata_i;
        mem_rready_c = bus.inct_rready_i;
`ifdef CC_RRESP_LAST_CHECK_EN
        rlast_c = bus.mem_rlast_i;
        if (mem_hs) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (bus.mem_rlast_i != last_beat) err_d = 1'b1;
          if (bus.mem_rlast_i) state_d = ST_IDLE;
        end
`else
        rlast_c = last_beat;
        if (mem_hs) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (last_beat) state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset silences every handshake output in the same cycle it is asserted.
    if (rst) begin
      pop_c        = 1'b0;
      mem_rready_c = 1'b0;
      rvalid_c     = 1'b0;
      rlast_c      = 1'b0;
      rdata_c      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      line_q  <= '0;
`ifdef CC_RRESP_LAST_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      line_q  <= line_d;
`ifdef CC_RRESP_LAST_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_pop_o     = pop_c;
  assign bus.mem_rready_o  = mem_rready_c;
  assign bus.inct_rvalid_o = rvalid_c;
  assign bus.inct_rlast_o  = rlast_c;
  assign bus.inct_rdata_o  = rdata_c;

`ifdef CC_RRESP_LAST_CHECK_EN
  assign bus.err_o = err_q;
  logic unused_c;
  assign unused_c = ^bus.req_offset_i[2:0];
`else
  assign bus.err_o = 1'b0;
  logic unused_c;
  assign unused_c = ^{bus.req_offset_i[2:0], bus.mem_rlast_i};
`endif

endmodule

// File: tb/tb_cc_rresp_serializer.sv
// Randomized bench for cc_rresp_serializer: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honors CC_RRESP_LAST_CHECK_EN if defined.
module tb_cc_rresp_serializer;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned N_BEATS = 8;
  localparam int unsigned LINE_W  = BEAT_W * N_BEATS;

  typedef struct {
    logic              hit;
    logic [5:0]        off;
    logic [LINE_W-1:0] line;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef enum int {M_IDLE, M_HIT, M_MISS} mode_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cc_rresp_serializer_if #(.BEAT_W(BEAT_W), .N_BEATS(N_BEATS)) bus ();
  cc_rresp_serializer #(.BEAT_W(BEAT_W), .N_BEATS(N_BEATS)) dut (.clk(clk), .rst(rst), .bus(bus));

  // reference model and stimulus state
  req_t        reqq[$];
  beat_t       memq[$];
  logic [63:0] expq[$];
  mode_t       mode;
  int          miss_n;
  logic        m_err;

  int   rr_pct, mv_pct, stall_cnt;
  logic rst_knob, mem_hold;
  logic prev_hold;
  logic [63:0] prev_data;

  logic [63:0] hs_log[$];
  logic [63:0] stall_log[$];
  int          pop_log[$];
  int          rlast_log[$];
  int          cyc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] tag);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = tag | 64'(k);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic push_req(input logic hit, input logic [5:0] off, input logic [LINE_W-1:0] line);
    req_t r;
    r.hit = hit; r.off = off; r.line = line;
    reqq.push_back(r);
  endtask

  task automatic push_beat(input logic [63:0] d, input logic last);
    beat_t b;
    b.data = d; b.last = last;
    memq.push_back(b);
  endtask

  task automatic push_miss_rnd();
    push_req(1'b0, 6'($urandom_range(63)), rnd_line());
    for (int i = 0; i < 8; i++) push_beat(rnd64(), i == 7);
  endtask

  // One clock cycle: drive at negedge, compare after settling, then advance the model.
  task automatic cycle();
    logic e_pop, e_mrdy, e_vld, e_last, mhs, stalling, dut_hs;
    logic [63:0] e_data;
    req_t r;
    @(negedge clk);
    cyc++;
    rst = rst_knob;
    bus.req_valid_i = (reqq.size() > 0);
    if (reqq.size() > 0) begin
      bus.req_hit_i    = reqq[0].hit;
      bus.req_offset_i = reqq[0].off;
      bus.req_line_i   = reqq[0].line;
    end else begin
      bus.req_hit_i    = 1'b0;
      bus.req_offset_i = '0;
      bus.req_line_i   = '0;
    end
    if (!mem_hold) bus.mem_rvalid_i = (memq.size() > 0) && ($urandom_range(99) < 32'(mv_pct));
    if (memq.size() > 0) begin
      bus.mem_rdata_i = memq[0].data;
      bus.mem_rlast_i = memq[0].last;
    end else begin
      bus.mem_rdata_i = '0;
      bus.mem_rlast_i = 1'b0;
    end
    stalling = (stall_cnt > 0);
    if (stalling) begin
      bus.inct_rready_i = 1'b0;
      stall_cnt--;
    end else begin
      bus.inct_rready_i = ($urandom_range(99) < 32'(rr_pct));
    end
    #1;

    e_pop = 1'b0; e_mrdy = 1'b0; e_vld = 1'b0; e_last = 1'b0; e_data = '0;
    if (!rst) begin
      case (mode)
        M_IDLE: e_pop = bus.req_valid_i;
        M_HIT: begin
          e_vld  = 1'b1;
          e_data = expq[0];
          e_last = (expq.size() == 1);
        end
        default: begin
          e_vld  = bus.mem_rvalid_i;
          e_data = bus.mem_rdata_i;
          e_mrdy = bus.inct_rready_i;
`ifdef CC_RRESP_LAST_CHECK_EN
          e_last = bus.mem_rlast_i;
`else
          e_last = ((miss_n % 8) == 7);
`endif
        end
      endcase
    end

    chk("req_pop", 64'(bus.req_pop_o), 64'(e_pop));
    chk("mem_rready", 64'(bus.mem_rready_o), 64'(e_mrdy));
    chk("inct_rvalid", 64'(bus.inct_rvalid_o), 64'(e_vld));
    chk("inct_rlast", 64'(bus.inct_rlast_o), 64'(e_last));
    chk("err", 64'(bus.err_o), 64'(m_err));
    if (!rst) chk("inct_rdata", bus.inct_rdata_o, e_data);
    if (!rst && prev_hold) begin
      chk("hold_rvalid", 64'(bus.inct_rvalid_o), 64'd1);
      chk("hold_rdata", bus.inct_rdata_o, prev_data);
    end
    prev_hold = !rst && bus.inct_rvalid_o && !bus.inct_rready_i;
    prev_data = bus.inct_rdata_o;

    dut_hs = !rst && bus.inct_rvalid_o && bus.inct_rready_i;
    if (dut_hs) hs_log.push_back(bus.inct_rdata_o);
    if (dut_hs && bus.inct_rlast_o) rlast_log.push_back(cyc);
    if (bus.req_pop_o) pop_log.push_back(cyc);
    if (stalling) stall_log.push_back(bus.inct_rdata_o);

    mhs = bus.mem_rvalid_i && e_mrdy;
    if (rst) begin
      mode = M_IDLE;
      expq.delete();
      m_err = 1'b0;
    end else begin
      case (mode)
        M_IDLE: if (bus.req_valid_i) begin
          r = reqq.pop_front();
          if (r.hit) begin
            for (int k = 0; k < 8; k++)
              expq.push_back(r.line[64*((int'(r.off[5:3]) + k) % 8) +: 64]);
            mode = M_HIT;
          end else begin
            miss_n = 0;
            mode   = M_MISS;
          end
        end
        M_HIT: if (bus.inct_rready_i) begin
          void'(expq.pop_front());
          if (expq.size() == 0) mode = M_IDLE;
        end
        default: if (mhs) begin
`ifdef CC_RRESP_LAST_CHECK_EN
          if (bus.mem_rlast_i != ((miss_n % 8) == 7)) m_err = 1'b1;
          if (bus.mem_rlast_i) mode = M_IDLE;
`else
          if ((miss_n % 8) == 7) mode = M_IDLE;
`endif
          miss_n++;
        end
      endcase
    end
    if (mhs) begin
      void'(memq.pop_front());
      mem_hold = 1'b0;
    end else begin
      mem_hold = bus.mem_rvalid_i;
    end
  endtask

  task automatic run_idle(input int budget, input string nm);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((reqq.size() > 0 || mode != M_IDLE) && n < budget);
    n_cmp++;
    if (reqq.size() > 0 || mode != M_IDLE) begin
      n_err++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", nm, n);
    end
  endtask

  initial begin
    logic [63:0] exp_hit[8];
    int n;
    logic flag;

    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_hit_i = 1'b0; bus.req_offset_i = '0; bus.req_line_i = '0;
    bus.mem_rdata_i = '0; bus.mem_rlast_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.inct_rready_i = 1'b0;
    mode = M_IDLE; miss_n = 0; m_err = 1'b0; cyc = 0;
    rr_pct = 100; mv_pct = 100; stall_cnt = 0;
    rst_knob = 1'b1; mem_hold = 1'b0; prev_hold = 1'b0; prev_data = '0;

    // reset and idle
    repeat (3) cycle();
    rst_knob = 1'b0;
    repeat (2) cycle();
    chk("idle_rvalid", 64'(bus.inct_rvalid_o), 64'd0);
    chk("idle_rdata", bus.inct_rdata_o, 64'd0);

    // hit, offset 0x18: critical word 3, wrap to words 0..2
    exp_hit = '{64'h1111_0000_0000_0003, 64'h1111_0000_0000_0004, 64'h1111_0000_0000_0005,
                64'h1111_0000_0000_0006, 64'h1111_0000_0000_0007, 64'h1111_0000_0000_0000,
                64'h1111_0000_0000_0001, 64'h1111_0000_0000_0002};
    hs_log.delete(); pop_log.delete(); rlast_log.delete();
    push_req(1'b1, 6'h18, mk_line(64'h1111_0000_0000_0000));
    run_idle(50, "hit");
    chki("hit_beats", hs_log.size(), 8);
    for (int i = 0; i < hs_log.size() && i < 8; i++) chk("hit_word", hs_log[i], exp_hit[i]);
    chki("hit_pops", pop_log.size(), 1);
    chki("hit_rlasts", rlast_log.size(), 1);
    if (pop_log.size() == 1 && rlast_log.size() == 1)
      chki("hit_rlast_delay", rlast_log[0] - pop_log[0], 8);

    // hit with 5-cycle stall on beat 2 (start word 1 -> beat 2 is word 3)
    hs_log.delete(); stall_log.delete();
    push_req(1'b1, 6'h08, mk_line(64'h2222_0000_0000_0000));
    flag = 1'b0; n = 0;
    while ((reqq.size() > 0 || mode != M_IDLE) && n < 100) begin
      if (!flag && mode == M_HIT && expq.size() == 6) begin
        stall_cnt = 5;
        flag = 1'b1;
      end
      cycle();
      n++;
    end
    chki("stall_done", n < 100 ? 1 : 0, 1);
    chki("stall_beats", hs_log.size(), 8);
    chki("stall_len", stall_log.size(), 5);
    foreach (stall_log[i]) chk("stall_data", stall_log[i], 64'h2222_0000_0000_0003);

    // back-to-back hit then miss, both queued up front
    pop_log.delete(); rlast_log.delete();
    push_req(1'b1, 6'($urandom_range(63)), rnd_line());
    push_miss_rnd();
    run_idle(100, "b2b");
    chki("b2b_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) chki("b2b_pop_gap", pop_log[1] - pop_log[0], 9);
    if (pop_log.size() == 2 && rlast_log.size() > 0) chki("b2b_pop_after_last", pop_log[1], rlast_log[0] + 1);

    // miss with random rvalid/rready toggling
    rr_pct = 50; mv_pct = 50;
    hs_log.delete();
    push_req(1'b0, 6'h00, rnd_line());
    for (int i = 0; i < 8; i++) push_beat(64'hA0 + 64'(i), i == 7);
    run_idle(500, "miss");
    chki("miss_beats", hs_log.size(), 8);
    for (int i = 0; i < hs_log.size() && i < 8; i++) chk("miss_data", hs_log[i], 64'hA0 + 64'(i));
    chk("miss_err", 64'(bus.err_o), 64'd0);

    // random mix
    rr_pct = 70; mv_pct = 60;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1) push_req(1'b1, 6'($urandom_range(63)), rnd_line());
      else push_miss_rnd();
    end
    run_idle(8000, "random");

    // reset while the 4th beat of a hit is presented
    rr_pct = 100; mv_pct = 100;
    hs_log.delete();
    push_req(1'b1, 6'h00, mk_line(64'h3333_0000_0000_0000));
    push_req(1'b1, 6'h28, mk_line(64'h4444_0000_0000_0000));
    flag = 1'b0; n = 0;
    while (!flag && n < 100) begin
      if (mode == M_HIT && expq.size() == 5) begin
        rst_knob = 1'b1;
        cycle();
        rst_knob = 1'b0;
        flag = 1'b1;
      end else begin
        cycle();
      end
      n++;
    end
    chki("rst_pre_beats", hs_log.size(), 3);
    hs_log.delete();
    run_idle(100, "post_rst");
    chki("post_rst_beats", hs_log.size(), 8);
    if (hs_log.size() > 0) chk("post_rst_first", hs_log[0], 64'h4444_0000_0000_0005);

    // miss whose memory rlast arrives early on beat 6
    hs_log.delete();
    push_req(1'b0, 6'h00, rnd_line());
    for (int i = 0; i < 8; i++) push_beat(64'hB0 + 64'(i), i == 5);
    run_idle(100, "early_last");
    cycle();
`ifdef CC_RRESP_LAST_CHECK_EN
    chki("early_last_beats", hs_log.size(), 6);
    chk("early_last_err", 64'(bus.err_o), 64'd1);
`else
    chki("early_last_beats", hs_log.size(), 8);
    chk("early_last_err", 64'(bus.err_o), 64'd0);
`endif
    rst_knob = 1'b1;
    repeat (2) cycle();
    memq.delete();
    mem_hold = 1'b0;
    rst_knob = 1'b0;
    cycle();
    chk("err_after_rst", 64'(bus.err_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cc_rresp_serializer.md
CC_RRESP_SERIALIZER -- requirements
Module: cc_rresp_serializer

Interface
REQ-001 Parameter BEAT_W, default 64, width of one INCT/memory R-channel data beat.
REQ-002 Parameter N_BEATS, default 8, beats per cache line (power of two); LINE_W = BEAT_W*N_BEATS (512); IDX_W = log2(N_BEATS) (3).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid_i  in  1  head of hit-flag/hit-data FIFOs is non-empty.
REQ-006 req_hit_i  in  1  head entry is a hit (1) or a miss (0).
REQ-007 req_offset_i  in  6  byte offset of the requested word; bits [5:3] give the critical word.
REQ-008 req_line_i  in  LINE_W  SRAM line for a hit; don't-care for a miss.
REQ-009 req_pop_o  out  1  pops both FIFO heads this cycle.
REQ-010 mem_rdata_i / mem_rlast_i / mem_rvalid_i  in  BEAT_W/1/1  memory R channel (WRAP burst, critical word first).
REQ-011 mem_rready_o  out  1  memory R channel ready.
REQ-012 inct_rdata_o / inct_rlast_o / inct_rvalid_o  out  BEAT_W/1/1  INCT R channel.
REQ-013 inct_rready_i  in  1  INCT R channel ready.
REQ-014 err_o  out  1  sticky protocol-error flag (see Configuration).

Function
REQ-015 FSM states IDLE, HIT, MISS; reset state IDLE.
REQ-016 IDLE: req_pop_o = req_valid_i; on req_valid_i=1 latch line, start index = req_offset_i[5:3], clear beat counter, go to HIT if req_hit_i=1 else MISS.
REQ-017 req_pop_o is 0 in HIT and MISS; exactly one pop per request.
REQ-018 First beat visible on INCT the cycle after the pop (1-cycle latency); one idle cycle between back-to-back requests.
REQ-019 HIT: inct_rvalid_o=1; inct_rdata_o = latched line word ((start + beat_cnt) mod N_BEATS), word k = bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k].
REQ-020 HIT: beat_cnt (IDX_W bits) increments only on inct_rvalid_o & inct_rready_i; index arithmetic wraps modulo N_BEATS (word 7 -> word 0).
REQ-021 HIT: inct_rlast_o = (beat_cnt == N_BEATS-1); handshake on last beat returns to IDLE.
REQ-022 MISS: combinational pass-through: inct_rvalid_o = mem_rvalid_i, inct_rdata_o = mem_rdata_i, mem_rready_o = inct_rready_i; beat_cnt increments on mem handshake.
REQ-023 mem_rready_o = 0 in IDLE and HIT; memory beats stall until their MISS entry reaches the head.
REQ-024 MISS ends on the handshake of the beat carrying inct_rlast_o (per Configuration); next state IDLE.
REQ-025 inct_rdata_o and inct_rvalid_o stay stable while inct_rvalid_o=1 and inct_rready_i=0 (HIT: held by state; MISS: by memory AXI rules).
REQ-026 Outside HIT/MISS: inct_rvalid_o=0, inct_rlast_o=0, inct_rdata_o=0.

Reset
REQ-027 rst=1 at a rising edge: state IDLE, beat_cnt=0, start index=0, latched line=0, err_o=0; takes effect that edge even mid-burst, abandoning the burst.
REQ-028 While rst=1: req_pop_o=0, mem_rready_o=0, inct_rvalid_o=0, inct_rlast_o=0.

Configuration
REQ-029 Macro CC_RRESP_LAST_CHECK_EN selects miss-burst termination.
REQ-030 Defined: MISS inct_rlast_o = mem_rlast_i; err_o sets (sticky until reset) on any MISS handshake where mem_rlast_i != (beat_cnt == N_BEATS-1); MISS ends on mem_rlast_i handshake.
REQ-031 Undefined: MISS inct_rlast_o = (beat_cnt == N_BEATS-1), mem_rlast_i ignored, MISS ends on 8th handshake, err_o tied 0.

Verification
REQ-032 Hit, offset=6'h18, line word k = 64'h1111_0000_0000_000k, rready=1 -> pop 1 cycle, then 8 consecutive beats words 3,4,5,6,7,0,1,2, rlast on word 2, IDLE next.
REQ-033 Miss, 8 memory beats 64'hA0..A7 with rvalid/rready toggling randomly -> INCT sees A0..A7 in order, mem_rready_o mirrors inct_rready_i, rlast on A7, err_o=0.
REQ-034 Hit with inct_rready_i=0 for 5 cycles on beat 2 -> rdata/rvalid held constant 5 cycles; burst then completes with exactly 8 beats.
REQ-035 Back-to-back hit then miss, both valid from cycle 0 -> second pop exactly 1 cycle after first burst's last handshake; mem_rready_o=0 throughout hit burst.
REQ-036 With CC_RRESP_LAST_CHECK_EN, mem_rlast_i asserted on 6th beat -> err_o=1 from next cycle, burst ends after 6th beat; without macro same stimulus -> 8 beats, err_o=0.
REQ-037 rst=1 on 4th beat of a hit burst -> next cycle IDLE, inct_rvalid_o=0, next request starts at its own critical word with beat_cnt=0.
